// File: rtl/rx_sync_pkg.sv
// Shared lane state encoding and default comma byte
// for the two-lane serial byte aligner.
package rx_sync_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } lane_st_t;

  localparam logic [7:0] COM_DEF = 8'hBC;

endpackage

// File: rtl/rx_sync_ctrl_if.sv
// Serial inputs and aligned byte outputs of rx_sync_ctrl.
// master: stimulus side; slave: aligner side.
interface rx_sync_ctrl_if;

  logic       enable;
  logic       D_0;
  logic       D_1;
  logic [7:0] data_out_0;
  logic [7:0] data_out_1;
  logic       valid_out_0;
  logic       valid_out_1;
  logic       active;

  modport master (
    output enable, D_0, D_1,
    input  data_out_0, data_out_1,
    input  valid_out_0, valid_out_1,
    input  active
  );

  modport slave (
    input  enable, D_0, D_1,
    output data_out_0, data_out_1,
    output valid_out_0, valid_out_1,
    output active
  );

endinterface

// File: rtl/rx_lane_align.sv
// One lane: shift register, bit/comma counters, SEARCH/LOCKING/ACTIVE FSM.
// Ports: i_enable, i_d serial bit; o_data last byte, o_hit data boundary, o_active.
module rx_lane_align
  import rx_sync_pkg::*;
#(
  parameter int         LOCK_COUNT = 4,
  parameter logic [7:0] COM        = COM_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_enable,
  input  logic       i_d,
  output logic [7:0] o_data,
  output logic       o_hit,
  output logic       o_active
);

  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] LC = CW'(LOCK_COUNT);

  // Only 7 history bits are stored; the byte is
  // completed by the bit arriving this cycle.
  logic [6:0]    r_sr;
  logic [7:0]    r_data;
  logic [2:0]    r_bit;
  logic [CW-1:0] r_com;
  lane_st_t      r_st;
  lane_st_t      w_nst;
  logic [7:0]    w_byte;
  logic          w_com;
  logic          w_bnd;
  logic [CW-1:0] w_com_inc;

  assign w_byte    = {r_sr, i_d};
  assign w_com     = (w_byte == COM);
  assign w_bnd     = (r_bit == 3'd7);
  assign w_com_inc = (r_com == LC) ? r_com
                                   : r_com + 1'b1;
  assign o_data    = r_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_st <= SEARCH;
    else        r_st <= w_nst;
  end

  always_comb begin
    w_nst = r_st;
    if (!i_enable) begin
      w_nst = SEARCH;
    end else begin
      unique case (r_st)
        SEARCH: begin
          if (w_com)
            w_nst = (LOCK_COUNT <= 1) ? ACTIVE
                                      : LOCKING;
        end
        LOCKING: begin
          if (w_bnd) begin
            if (!w_com)            w_nst = SEARCH;
            else if (w_com_inc == LC) w_nst = ACTIVE;
          end
        end
        ACTIVE:  w_nst = ACTIVE;
        default: w_nst = SEARCH;
      endcase
    end
  end

  always_comb begin
    o_active = (r_st == ACTIVE);
    o_hit    = i_enable && o_active
               && w_bnd && !w_com;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr   <= '0;
      r_data <= '0;
      r_bit  <= '0;
      r_com  <= '0;
    end else begin
      r_sr <= w_byte[6:0];
      if (o_hit) r_data <= w_byte;
      if (!i_enable || r_st == SEARCH) begin
        // A comma found while searching defines
        // the byte boundary: phase restarts at 0.
        r_bit <= '0;
        r_com <= (i_enable && w_com) ? CW'(1) : '0;
      end else begin
        r_bit <= r_bit + 3'd1;
        if (r_st == LOCKING && w_bnd)
          r_com <= w_com ? w_com_inc : '0;
      end
    end
  end

endmodule

// File: rtl/rx_sync_ctrl.sv
// Two-lane comma aligner: lanes lock independently, strobes gated by active.
// Ports: clk, reset (async, low), bus (slave: enable, D_n in; data/valid/active out).
module rx_sync_ctrl
  import rx_sync_pkg::*;
#(
  parameter int         LOCK_COUNT = 4,
  parameter logic [7:0] COM        = COM_DEF
) (
  input  logic           clk,
  input  logic           reset,
  rx_sync_ctrl_if.slave  bus
);

  logic       w_hit0;
  logic       w_hit1;
  logic       w_act0;
  logic       w_act1;
  logic [7:0] w_data0;
  logic [7:0] w_data1;
  logic       r_active;
  logic       r_v0;
  logic       r_v1;

  rx_lane_align #(
    .LOCK_COUNT (LOCK_COUNT),
    .COM        (COM)
  ) u_lane0 (
    .clk      (clk),
    .reset    (reset),
    .i_enable (bus.enable),
    .i_d      (bus.D_0),
    .o_data   (w_data0),
    .o_hit    (w_hit0),
    .o_active (w_act0)
  );

  rx_lane_align #(
    .LOCK_COUNT (LOCK_COUNT),
    .COM        (COM)
  ) u_lane1 (
    .clk      (clk),
    .reset    (reset),
    .i_enable (bus.enable),
    .i_d      (bus.D_1),
    .o_data   (w_data1),
    .o_hit    (w_hit1),
    .o_active (w_act1)
  );

  // Strobes use the pre-edge active, so bytes a
  // faster lane completes before active rises drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active <= 1'b0;
      r_v0     <= 1'b0;
      r_v1     <= 1'b0;
    end else begin
      r_active <= bus.enable && w_act0 && w_act1;
      r_v0     <= bus.enable && w_hit0 && r_active;
      r_v1     <= bus.enable && w_hit1 && r_active;
    end
  end

  assign bus.data_out_0  = w_data0;
  assign bus.data_out_1  = w_data1;
  assign bus.valid_out_0 = r_v0;
  assign bus.valid_out_1 = r_v1;
  assign bus.active      = r_active;

endmodule

// File: doc/rx_sync_ctrl.md
RX_SYNC_CTRL -- requirements
Module: rx_sync_ctrl

Interface
REQ-001 Parameter LOCK_COUNT, default 4: number of consecutive aligned COM bytes (8'hBC) required per lane to declare lock.
REQ-002 Parameter COM, default 8'hBC: comma/idle byte used for alignment.
REQ-003 clk  in  1  bit-rate clock; one serial bit per lane is sampled per rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 enable  in  1  synchronous enable; low forces both lanes to SEARCH.
REQ-006 D_0  in  1  serial data, lane 0, MSB first.
REQ-007 D_1  in  1  serial data, lane 1, MSB first.
REQ-008 data_out_0  out  8  last aligned non-COM byte, lane 0.
REQ-009 data_out_1  out  8  last aligned non-COM byte, lane 1.
REQ-010 valid_out_0  out  1  one-cycle strobe; data_out_0 updated this cycle.
REQ-011 valid_out_1  out  1  one-cycle strobe; data_out_1 updated this cycle.
REQ-012 active  out  1  high while both lanes are in ACTIVE.

Function
REQ-013 Each lane SHALL shift its input into an 8-bit register every cycle: sr <= {sr[6:0], D}; the byte is the value {sr[6:0], D} at the sampling edge.
REQ-014 Each lane SHALL run an FSM with states SEARCH, LOCKING, ACTIVE.
REQ-015 SEARCH: compare on every cycle; on byte == COM go to LOCKING, set com_cnt = 1, set bit_cnt = 0 (defines the byte boundary).
REQ-016 bit_cnt SHALL increment modulo 8 outside SEARCH; a byte boundary is the cycle in which bit_cnt == 7, i.e. exactly 8 cycles after the previous boundary.
REQ-017 LOCKING, at a boundary: byte == COM -> com_cnt + 1; when com_cnt reaches LOCK_COUNT go to ACTIVE; byte != COM -> SEARCH, com_cnt = 0.
REQ-018 LOCK_COUNT == 1 SHALL enter ACTIVE directly from SEARCH on the first COM.
REQ-019 ACTIVE, at a boundary: byte != COM -> data_out_n <= byte and, if active is high, valid_out_n = 1 for exactly one cycle; byte == COM -> no strobe, data_out_n unchanged.
REQ-020 ACTIVE SHALL be exited only by enable low or reset (no loss-of-lock detection in this block).
REQ-021 active SHALL be registered, rising the cycle after the second lane reaches ACTIVE; lane skew of any length is tolerated, and bytes completed by the faster lane before active rises are dropped.
REQ-022 enable low: both FSMs -> SEARCH, com_cnt = 0, bit_cnt = 0, valid_out_n = 0, active = 0 on the next edge; shift registers keep shifting.
REQ-023 Latency: valid_out_n SHALL assert on the edge that samples the byte's 8th bit (zero extra pipeline stages).
REQ-024 com_cnt width SHALL be $clog2(LOCK_COUNT+1) and SHALL saturate, never wrap.

Reset
REQ-025 On reset low, asynchronously: sr = 0, bit_cnt = 0, com_cnt = 0, FSM = SEARCH, data_out_n = 8'h00, valid_out_n = 0, active = 0.
REQ-026 Reset asserted mid-operation SHALL discard partial bytes; after release, alignment restarts from SEARCH.

Structure
REQ-027 Shared package rx_sync_pkg SHALL hold the lane state encoding (SEARCH=2'd0, LOCKING=2'd1, ACTIVE=2'd2) and the default COM constant 8'hBC.
REQ-028 The per-lane shift register, counters and FSM SHALL be one sub-module, rx_lane_align, instantiated twice; the top holds only active and valid gating.

Verification
REQ-029 Four aligned BC bytes on both lanes, then 8'hA5 on lane 0 and 8'h3C on lane 1 -> active rises after the 4th BC; one valid strobe per lane with data 8'hA5 and 8'h3C.
REQ-030 Bitstream 1,0,1,1,1,0,0,1,1,0 followed by BC bytes -> no false lock on the preamble; lock after 4 BCs measured from the first aligned BC.
REQ-031 Three BCs then 8'h00 on lane 0 -> lane 0 returns to SEARCH, active stays 0, no valid strobe; re-lock on four new BCs.
REQ-032 Lane 1 delayed 3 bits relative to lane 0 -> both lanes lock independently; active rises only after lane 1 locks; data bytes on both lanes are correct.
REQ-033 enable deasserted for 1 cycle while active -> active and valid fall next edge; re-lock requires four fresh BCs.
REQ-034 Reset pulsed low mid-byte in ACTIVE -> all outputs 0 immediately (asynchronous); full re-alignment required after release.
